// File: rtl/fb_rect_fill_160x120.sv
// Rectangle-fill engine in front of the 160x120 framebuffer write port.
// A latched rectangle command is written one pixel per clock, clipped to the
// screen. MCU single-pixel writes pass through with priority and stall the
// fill without losing any pixel. FB_* outputs are registered (1-cycle latency).
module fb_rect_fill_160x120 #(
    parameter int unsigned H_RES = 160,
    parameter int unsigned V_RES = 120
) (
    input  logic        CLK_50MHz,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  X0,
    input  logic [6:0]  Y0,
    input  logic [7:0]  W,
    input  logic [6:0]  H,
    input  logic [15:0] COLOR,
    input  logic [14:0] MCU_WA,
    input  logic [15:0] MCU_WD,
    input  logic        MCU_WE,
    output logic [14:0] FB_WA,
    output logic [15:0] FB_WD,
    output logic        FB_WE,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [8:0]  X_LIM  = 9'(H_RES);
    localparam logic [7:0]  Y_LIM  = 8'(V_RES);
    localparam logic [14:0] STRIDE = 15'(H_RES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    // Latched command
    logic [7:0]  x0_q;
    logic [6:0]  y0_q;
    logic [7:0]  w_q;
    logic [6:0]  h_q;
    logic [15:0] color_q;

    // Fill walker
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] row_base;
    logic [8:0]  x_end;
    logic [7:0]  y_end;

    // Setup-time calculations, widened so the sums cannot wrap
    logic [8:0]  x_sum;
    logic [7:0]  y_sum;
    logic [8:0]  x_end_calc;
    logic [7:0]  y_end_calc;
    logic [14:0] row_base_calc;
    logic        cmd_empty;

    // Walker position flags and control strobes
    logic        last_col;
    logic        last_row;
    logic        accept;
    logic        fill_go;
    logic [14:0] fill_addr;

    // Clip bounds, empty-command detection and shift-add row base (Y0*160)
    always_comb begin
        x_sum         = {1'b0, x0_q} + {1'b0, w_q};
        y_sum         = {1'b0, y0_q} + {1'b0, h_q};
        x_end_calc    = (x_sum < X_LIM) ? x_sum : X_LIM;
        y_end_calc    = (y_sum < Y_LIM) ? y_sum : Y_LIM;
        cmd_empty     = (w_q == '0) || (h_q == '0) ||
                        ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);
        // 160 = 128 + 32, so the row base needs only two shifted copies of Y0
        row_base_calc = ({8'b0, y0_q} << 7) + ({8'b0, y0_q} << 5);
    end

    // Walker position relative to the clipped rectangle
    always_comb begin
        last_col  = ({1'b0, x} == (x_end - 9'd1));
        last_row  = ({1'b0, y} == (y_end - 8'd1));
        fill_addr = row_base + {7'b0, x};
    end

    // State register
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = cmd_empty ? FINISH : FILL;
            end
            FILL: begin
                if (!MCU_WE && last_col && last_row) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs and fill/accept strobes decoded from the current state
    always_comb begin
        BUSY    = (state != IDLE);
        DONE    = (state == FINISH);
        accept  = (state == IDLE) && START;
        fill_go = (state == FILL) && !MCU_WE;
    end

    // Command latch and raster walker
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            x_end    <= '0;
            y_end    <= '0;
        end else begin
            if (accept) begin
                x0_q    <= X0;
                y0_q    <= Y0;
                w_q     <= W;
                h_q     <= H;
                color_q <= COLOR;
            end
            if (state == SETUP) begin
                x        <= x0_q;
                y        <= y0_q;
                row_base <= row_base_calc;
                x_end    <= x_end_calc;
                y_end    <= y_end_calc;
            end
            // A stalled cycle leaves the walker untouched, so no pixel is dropped
            if (fill_go) begin
                if (last_col) begin
                    x        <= x0_q;
                    y        <= y + 7'd1;
                    row_base <= row_base + STRIDE;
                end else begin
                    x <= x + 8'd1;
                end
            end
        end
    end

    // Registered write port: MCU write wins, otherwise the fill pixel; hold when idle
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            FB_WA <= '0;
            FB_WD <= '0;
            FB_WE <= 1'b0;
        end else if (MCU_WE) begin
            FB_WA <= MCU_WA;
            FB_WD <= MCU_WD;
            FB_WE <= 1'b1;
        end else if (fill_go) begin
            FB_WA <= fill_addr;
            FB_WD <= color_q;
            FB_WE <= 1'b1;
        end else begin
            FB_WE <= 1'b0;
        end
    end

endmodule
